// File: rtl/ttt_pkg.sv
// Shared constants and types for the tic-tac-toe bot player.
// Cells are numbered a..i = 0..8, row-major.
package ttt_pkg;

    localparam logic [3:0] A = 4'd0;
    localparam logic [3:0] B = 4'd1;
    localparam logic [3:0] C = 4'd2;
    localparam logic [3:0] D = 4'd3;
    localparam logic [3:0] E = 4'd4;
    localparam logic [3:0] F = 4'd5;
    localparam logic [3:0] G = 4'd6;
    localparam logic [3:0] H = 4'd7;
    localparam logic [3:0] I = 4'd8;

    localparam logic [3:0] NO_MOVE = 4'hF;

    // Scan order: rows, columns, then the two diagonals.
    localparam logic [3:0] LINES [8][3] = '{
        '{A, B, C}, '{D, E, F}, '{G, H, I},
        '{A, D, G}, '{B, E, H}, '{C, F, I},
        '{A, E, I}, '{C, E, G}
    };

    localparam logic [3:0] CORNERS [4] = '{A, C, G, I};
    localparam logic [3:0] EDGES   [4] = '{B, D, F, H};

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DECIDE,
        PRESS,
        WAIT_ACK
    } state_t;

    // Indices above 8 (NO_MOVE) shift out and yield an all-zero vector.
    function automatic logic [8:0] onehot9(input logic [3:0] idx);
        return 9'b1 << idx;
    endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Evaluates one three-cell line: can player 2 win on it, must player 1 be
// blocked on it, and where in the line is the (first) empty cell.
module ttt_line_eval (
    input  logic [2:0] p1_i,
    input  logic [2:0] p2_i,
    output logic       win_valid_o,
    output logic       block_valid_o,
    output logic [1:0] empty_pos_o
);

    logic [2:0] empty;
    logic [1:0] n_p1;
    logic [1:0] n_p2;
    logic [1:0] n_empty;

    assign empty   = ~(p1_i | p2_i);
    assign n_p1    = {1'b0, p1_i[0]} + {1'b0, p1_i[1]} + {1'b0, p1_i[2]};
    assign n_p2    = {1'b0, p2_i[0]} + {1'b0, p2_i[1]} + {1'b0, p2_i[2]};
    assign n_empty = {1'b0, empty[0]} + {1'b0, empty[1]} + {1'b0, empty[2]};

    assign win_valid_o   = (n_p2 == 2'd2) && (n_empty == 2'd1);
    assign block_valid_o = (n_p1 == 2'd2) && (n_empty == 2'd1);

    always_comb begin
        if (empty[0]) begin
            empty_pos_o = 2'd0;
        end else if (empty[1]) begin
            empty_pos_o = 2'd1;
        end else begin
            empty_pos_o = 2'd2;
        end
    end

endmodule

// File: rtl/ttt_bot_player.sv
// Player-2 bot: snapshots the board, scans the eight lines one per cycle,
// picks a move by fixed priority and presses the matching cell button.
module ttt_bot_player
    import ttt_pkg::*;
#(
    parameter int PRESS_CYCLES = 4,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] p1_cells,
    input  logic [8:0] p2_cells,
    input  logic       p2_turn,
    input  logic       game_over,
    output logic [8:0] press,
    output logic [3:0] move_idx,
    output logic       busy,
    output logic       move_done,
    output logic       timeout
);

    localparam logic [9:0] PRESS_LAST = 10'(PRESS_CYCLES - 1);
    localparam logic [9:0] ACK_LAST   = 10'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [2:0] line_q, line_d;
    logic [9:0] cnt_q, cnt_d;
    logic [8:0] p1_snap_q, p1_snap_d;
    logic [8:0] p2_snap_q, p2_snap_d;
    logic       win_vld_q, win_vld_d;
    logic       blk_vld_q, blk_vld_d;
    logic [3:0] win_idx_q, win_idx_d;
    logic [3:0] blk_idx_q, blk_idx_d;
    logic [8:0] press_q, press_d;
    logic [3:0] move_idx_q, move_idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tmo_q, tmo_d;

    logic       start;
    logic       abort;
    logic       ack;
    logic [2:0] lp1, lp2;
    logic       lwin, lblk;
    logic [1:0] lpos;
    logic [3:0] lcell;
    logic [8:0] empty_cells;
    logic [3:0] pick;

    assign start = enable && p2_turn && !game_over;
    assign abort = (state_q != IDLE) && (game_over || !enable);
    assign ack   = !p2_turn && |(p2_cells & onehot9(move_idx_q));

    // The single line evaluator sees the snapshot line selected by line_q.
    always_comb begin
        lp1 = '0;
        lp2 = '0;
        for (int k = 0; k < 3; k++) begin
            lp1[k] = p1_snap_q[LINES[line_q][k]];
            lp2[k] = p2_snap_q[LINES[line_q][k]];
        end
    end

    ttt_line_eval u_line_eval (
        .p1_i          (lp1),
        .p2_i          (lp2),
        .win_valid_o   (lwin),
        .block_valid_o (lblk),
        .empty_pos_o   (lpos)
    );

    assign lcell = LINES[line_q][lpos];

    // Move priority: win, block, centre, first corner, first edge.
    always_comb begin
        empty_cells = ~(p1_snap_q | p2_snap_q);
        pick        = NO_MOVE;
        if (win_vld_q) begin
            pick = win_idx_q;
        end else if (blk_vld_q) begin
            pick = blk_idx_q;
        end else if (empty_cells[E]) begin
            pick = E;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                if (empty_cells[CORNERS[k]]) pick = CORNERS[k];
            end
            if (pick == NO_MOVE) begin
                for (int k = 3; k >= 0; k--) begin
                    if (empty_cells[EDGES[k]]) pick = EDGES[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start) state_d = SCAN;
            SCAN:     if (line_q == 3'd7) state_d = DECIDE;
            DECIDE:   state_d = (pick == NO_MOVE) ? IDLE : PRESS;
            PRESS:    if (cnt_q == PRESS_LAST) state_d = WAIT_ACK;
            WAIT_ACK: if (ack || (cnt_q == ACK_LAST)) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_comb begin
        line_d     = line_q;
        cnt_d      = cnt_q;
        p1_snap_d  = p1_snap_q;
        p2_snap_d  = p2_snap_q;
        win_vld_d  = win_vld_q;
        win_idx_d  = win_idx_q;
        blk_vld_d  = blk_vld_q;
        blk_idx_d  = blk_idx_q;
        press_d    = press_q;
        move_idx_d = move_idx_q;
        busy_d     = (state_d != IDLE);
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    p1_snap_d = p1_cells;
                    p2_snap_d = p2_cells;
                    line_d    = '0;
                    win_vld_d = 1'b0;
                    blk_vld_d = 1'b0;
                end
            end
            SCAN: begin
                line_d = line_q + 3'd1;
                if (lwin && !win_vld_q) begin
                    win_vld_d = 1'b1;
                    win_idx_d = lcell;
                end
                if (lblk && !blk_vld_q) begin
                    blk_vld_d = 1'b1;
                    blk_idx_d = lcell;
                end
            end
            DECIDE: begin
                move_idx_d = pick;
                press_d    = onehot9(pick);
                cnt_d      = '0;
            end
            PRESS: begin
                if (cnt_q == PRESS_LAST) begin
                    press_d = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            WAIT_ACK: begin
                if (ack) begin
                    done_d = 1'b1;
                end else if (cnt_q == ACK_LAST) begin
                    tmo_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: ;
        endcase
        // An abort leaves move_idx untouched and suppresses both pulses.
        if (abort) begin
            press_d    = '0;
            move_idx_d = move_idx_q;
            done_d     = 1'b0;
            tmo_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q     <= '0;
            cnt_q      <= '0;
            p1_snap_q  <= '0;
            p2_snap_q  <= '0;
            win_vld_q  <= 1'b0;
            win_idx_q  <= '0;
            blk_vld_q  <= 1'b0;
            blk_idx_q  <= '0;
            press_q    <= '0;
            move_idx_q <= NO_MOVE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            line_q     <= line_d;
            cnt_q      <= cnt_d;
            p1_snap_q  <= p1_snap_d;
            p2_snap_q  <= p2_snap_d;
            win_vld_q  <= win_vld_d;
            win_idx_q  <= win_idx_d;
            blk_vld_q  <= blk_vld_d;
            blk_idx_q  <= blk_idx_d;
            press_q    <= press_d;
            move_idx_q <= move_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
        end
    end

    assign press     = press_q;
    assign move_idx  = move_idx_q;
    assign busy      = busy_q;
    assign move_done = done_q;
    assign timeout   = tmo_q;

endmodule
